// File: rtl/reg_file_param.sv
// Two-read/one-write register file with registered reads, optional write-first bypass and a hardware clear sweep.
// Latency: reads are 1 cycle (address at edge n, operand valid after edge n+1); writes land at the edge they are sampled.
// Backpressure: none; while busy the array is being zeroed, write_enable/clear_req are ignored and operands read 0.
//
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   left_addr, right_addr    : read addresses for operand ports A/B
//   dest_addr, result        : write address / write data, qualified by write_enable
//   clear_req                : one-cycle request to zero the whole array
//   left_operand, right_operand : registered read data
//   busy                     : high while the clear sweep runs
//   addr_err                 : registered pulse for any enabled access with address >= DEPTH
module reg_file_param #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] left_addr,
  input  logic [ADDR_W-1:0] right_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [DATA_W-1:0] result,
  input  logic              write_enable,
  input  logic              clear_req,
  output logic [DATA_W-1:0] left_operand,
  output logic [DATA_W-1:0] right_operand,
  output logic              busy,
  output logic              addr_err
);

  // Index width for the storage array; addresses are range-checked before
  // being narrowed to this width, so the truncation never aliases.
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              l_ok, r_ok, d_ok;
  logic              l_zero, r_zero, d_zero;
  logic              wr_en;
  logic [DATA_W-1:0] l_nxt, r_nxt;

  always_comb begin
    l_ok   = ({1'b0, left_addr}  < DEPTH_A);
    r_ok   = ({1'b0, right_addr} < DEPTH_A);
    d_ok   = ({1'b0, dest_addr}  < DEPTH_A);
    l_zero = (ZERO_REG != 0) && (left_addr  == '0);
    r_zero = (ZERO_REG != 0) && (right_addr == '0);
    d_zero = (ZERO_REG != 0) && (dest_addr  == '0);
    // A write that is dropped (zero register, out of range, sweep running)
    // must not be forwarded either, so bypass keys off the same qualifier.
    wr_en  = (state == S_IDLE) && write_enable && d_ok && !d_zero;

    l_nxt = '0;
    if (l_ok && !l_zero) begin
      if ((BYPASS != 0) && wr_en && (dest_addr == left_addr))
        l_nxt = result;
      else
        l_nxt = mem[left_addr[IDX_W-1:0]];
    end

    r_nxt = '0;
    if (r_ok && !r_zero) begin
      if ((BYPASS != 0) && wr_en && (dest_addr == right_addr))
        r_nxt = result;
      else
        r_nxt = mem[right_addr[IDX_W-1:0]];
    end
  end

  // Control FSM with registered outputs. busy tracks the CLEAR state exactly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_CLEAR;
      clr_cnt       <= '0;
      busy          <= 1'b1;
      left_operand  <= '0;
      right_operand <= '0;
      addr_err      <= 1'b0;
    end else if (state == S_CLEAR) begin
      left_operand  <= '0;
      right_operand <= '0;
      addr_err      <= 1'b0;
      if (clr_cnt == LAST) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end else begin
      left_operand  <= l_nxt;
      right_operand <= r_nxt;
      addr_err      <= !l_ok || !r_ok || (write_enable && !d_ok);
      if (clear_req) begin
        state   <= S_CLEAR;
        busy    <= 1'b1;
        clr_cnt <= '0;
      end
    end
  end

  // Storage has no reset; the sweep zeroes it one entry per cycle.
  // A write accepted together with clear_req lands now and is overwritten
  // by the sweep that starts on the next edge.
  always_ff @(posedge clock) begin
    if (state == S_CLEAR)
      mem[clr_cnt] <= '0;
    else if (wr_en)
      mem[dest_addr[IDX_W-1:0]] <= result;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised two-read/one-write register file for the datapath operand stage. It generalises data width and depth and adds registered reads with optional write-to-read bypass. It also provides a hardwired zero register and a hardware clear sequencer that zeroes the whole array after reset or on request. It sits between the instruction decode stage, which supplies the addresses, and the ALU, which consumes the operands and returns the result.

## Interface
- DATA_W, default 64: width of each entry and of the operand/result buses.
- DEPTH, default 64: number of entries; need not be a power of two.
- ADDR_W, default 8: address bus width; must satisfy 2^ADDR_W >= DEPTH.
- ZERO_REG, default 1: 1 means entry 0 always reads 0 and writes to it are dropped.
- BYPASS, default 1: 1 means a same-cycle write to the read address is forwarded (write-first); 0 means read-first.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- left_addr  in  ADDR_W  read port A address.
- right_addr  in  ADDR_W  read port B address.
- dest_addr  in  ADDR_W  write address.
- result  in  DATA_W  write data.
- write_enable  in  1  write strobe.
- clear_req  in  1  one-cycle request to zero the whole array.
- left_operand  out  DATA_W  registered read data, port A.
- right_operand  out  DATA_W  registered read data, port B.
- busy  out  1  high while the clear sequencer runs.
- addr_err  out  1  registered one-cycle pulse on any enabled access with address >= DEPTH.

## Operation
- Reset (reset_n low), asynchronous:
  - left_operand, right_operand and addr_err go to 0.
  - busy goes to 1; the FSM enters CLEAR with clear counter 0.
  - Array contents are not reset directly; the CLEAR sweep zeroes them.
- FSM states:
  - CLEAR: each cycle, writes 0 to entry[counter] and increments the counter. After writing entry DEPTH-1 it goes to IDLE, and busy drops on that transition.
  - IDLE: if clear_req is 1, go to CLEAR with counter 0 next cycle. Otherwise stay.
- While in CLEAR:
  - write_enable is ignored.
  - Both operands are driven to 0.
  - clear_req is ignored; the sweep is not restarted.
- Reads:
  - Each operand register loads the selected entry every cycle.
  - Address 0 returns 0 when ZERO_REG=1.
  - An address >= DEPTH returns 0 and raises addr_err.
- Bypass (BYPASS=1): if write_enable=1 and dest_addr equals a read address in the same cycle, that operand loads result. Exceptions: no bypass when the target is the dropped zero register or an out-of-range address.
- Writes: write_enable=1 in IDLE with dest_addr < DEPTH updates the entry at the clock edge.
  - Writes to entry 0 are dropped when ZERO_REG=1.
  - Writes with dest_addr >= DEPTH are dropped and raise addr_err.
- Simultaneous write and clear_req in IDLE: the write is performed, then the sweep starts next cycle and overwrites it.
- addr_err is checked on left_addr and right_addr every IDLE cycle, and on dest_addr when write_enable=1. It is never raised in CLEAR.

## Timing
- Read latency is 1 cycle: an address presented at edge n gives data valid after edge n+1.
- Write-to-read:
  - BYPASS=1: a read in the same cycle as the write returns the new data.
  - BYPASS=0: a read in the same cycle returns old data; new data is visible from the next read cycle.
- Clear duration:
  - busy rises the cycle after clear_req is sampled and stays high for exactly DEPTH cycles.
  - After reset release, busy stays high for DEPTH cycles starting at the first clock edge.
  - The first accepted write is at the edge after busy falls.
- Reset asserted mid-sweep: the counter restarts at 0 after release and a full DEPTH-cycle sweep runs again.
- addr_err is asserted in the cycle after the offending access, for 1 cycle.

## Test plan
- Reset, then sweep: release reset_n -> busy high for 64 cycles, then reads of addr 5 and 63 return 0.
- Write then read (BYPASS=1): write 0xDEAD_BEEF_0000_0001 to addr 7, with left_addr=7 in the same cycle -> left_operand equals that value after 1 cycle. Repeat with BYPASS=0 -> old value 0 first, new value on the following read.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to addr 0 -> left_operand and right_operand read 0. With ZERO_REG=0 the value is returned.
- Out of range (DEPTH=40): write to addr 45 -> addr_err pulses 1 cycle and no entry changes. Read addr 45 -> returns 0 and raises addr_err.
- Clear with a pending write: write 0x1234 to addr 3 with clear_req in the same cycle -> busy high 64 cycles; writes issued during busy are dropped; afterwards addr 3 reads 0.
- Reset mid-sweep: assert reset_n low at sweep cycle 20, release -> operands read 0 immediately, and busy stays high for a full 64 cycles.
